// File: rtl/deal_scheduler.sv
// deal_scheduler: queues card-draw requests and feeds the print engine one command at a time.
// Optional HOLE_CARD_EN: dealer slot 1 is printed face-down until a reveal pulse re-queues it.
module deal_scheduler #(
  parameter int DEPTH      = 4,
  parameter int BASE_X     = 4,
  parameter int SLOT_PITCH = 12,
  parameter int PLAYER_Y   = 90,
  parameter int DEALER_Y   = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_req,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dealer,
  input  logic [2:0]  req_slot,
  input  logic [5:0]  req_card,
  output logic        req_err,
`ifdef HOLE_CARD_EN
  input  logic        reveal,
`endif
  output logic        writeprint,
  output logic        init,
  output logic [5:0]  card,
  output logic [14:0] orig,
  input  logic        waitrequest,
  output logic        busy
);
  // state | meaning
  // IDLE  | no command outstanding; serve pending clear first, then the FIFO
  // ISSUE | writeprint held with stable command until engine accepts
  // WAIT  | accepted; wait for waitrequest to rise and fall again

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state, state_nxt;
  logic [20:0] mem [DEPTH];
  logic [20:0] rd_data;
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        clr_pend, seen_hi;
  logic        full, req_bad, push_try, push_ok;
  logic        pop, flush, wr_en;
  logic [20:0] wr_data;
  logic [7:0]  req_x;
  logic [6:0]  req_y;
  logic [5:0]  store_card;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == FULL_CNT);
  assign req_ready = ~full;
  assign req_bad   = (req_card[5:2] == 4'd13) || (req_card[5:2] == 4'd15);
  // A clear in the same cycle discards the request outright.
  assign push_try  = req_valid && req_ready && !clear_req;
  assign push_ok   = push_try && !req_bad;
  assign req_x     = 8'(BASE_X + int'(req_slot) * SLOT_PITCH);
  assign req_y     = req_dealer ? 7'(DEALER_Y) : 7'(PLAYER_Y);
  assign rd_data   = mem[rd_ptr[AW-1:0]];
  assign busy      = (state != IDLE) || clr_pend || (count != '0);

`ifdef HOLE_CARD_EN
  logic [5:0] hole_q;
  logic       reveal_pend, reveal_fire, hole_slot;

  assign hole_slot   = req_dealer && (req_slot == 3'd1);
  // A live request owns the write port; the reveal waits for a free cycle.
  assign reveal_fire = reveal_pend && !push_ok && !full && !clear_req;
  assign store_card  = hole_slot ? {4'd14, req_card[1:0]} : req_card;

  always_comb begin
    wr_en   = push_ok || reveal_fire;
    wr_data = {req_x, req_y, store_card};
    if (reveal_fire) wr_data = {8'(BASE_X + SLOT_PITCH), 7'(DEALER_Y), hole_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hole_q      <= '0;
      reveal_pend <= 1'b0;
    end else begin
      if (push_ok && hole_slot) hole_q <= req_card;
      if (clear_req)            reveal_pend <= 1'b0;
      else if (reveal)          reveal_pend <= 1'b1;
      else if (reveal_fire)     reveal_pend <= 1'b0;
    end
  end
`else
  assign store_card = req_card;

  always_comb begin
    wr_en   = push_ok;
    wr_data = {req_x, req_y, store_card};
  end
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (clr_pend) begin
          flush     = 1'b1;
          state_nxt = ISSUE;
        end else if (count != '0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   if (!waitrequest) state_nxt = WAIT;
      WAIT:    if (seen_hi && !waitrequest) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      clr_pend   <= 1'b1;
      seen_hi    <= 1'b0;
      req_err    <= 1'b0;
      writeprint <= 1'b0;
      init       <= 1'b0;
      card       <= '0;
      orig       <= '0;
    end else begin
      state   <= state_nxt;
      req_err <= push_try && req_bad;

      if (clear_req)  clr_pend <= 1'b1;
      else if (flush) clr_pend <= 1'b0;

      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      // Flush keeps anything written on this same edge.
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PTR_ONE;

      if (flush) begin
        writeprint <= 1'b1;
        init       <= 1'b1;
        card       <= '0;
        orig       <= '0;
      end else if (pop) begin
        writeprint <= 1'b1;
        init       <= 1'b0;
        card       <= rd_data[5:0];
        orig       <= rd_data[20:6];
      end else if (state == ISSUE && !waitrequest) begin
        writeprint <= 1'b0;
        init       <= 1'b0;
        seen_hi    <= 1'b0;
      end else if (state == WAIT && waitrequest) begin
        seen_hi    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deal_scheduler.sv
// Scoreboard bench for deal_scheduler: directed scenarios, then randomized traffic against a print-engine model.
// Define HOLE_CARD_EN to also exercise the face-down dealer card path.
module tb_deal_scheduler;
  logic        clk = 1'b0;
  logic        rst_n, clear_req, req_valid, req_ready, req_dealer, req_err;
  logic [2:0]  req_slot;
  logic [5:0]  req_card;
  logic        writeprint, init, waitrequest, busy;
  logic [5:0]  card;
  logic [14:0] orig;
`ifdef HOLE_CARD_EN
  logic        reveal;
`endif

  localparam logic [21:0] INIT_CMD = {1'b1, 6'd0, 15'd0};

  int          total = 0;
  int          bad = 0;
  int          n_cmds = 0;
  logic [21:0] exp_q[$];
  logic [21:0] last_exp, mon_cur;
  logic        last_valid = 1'b0;
  logic        prev_wp = 1'b0;
  logic        exp_err = 1'b0;
  logic        have_acc = 1'b0;
  logic        wr_hi_since = 1'b0;
  logic        mon_en = 1'b0;
  logic        clr_wait = 1'b1;
  logic [5:0]  hole_m = 6'd0;
  logic [5:0]  mon_card;

  logic        eng_force = 1'b0;
  logic        eng_rand = 1'b0;
  int          cfg_pre = 0;
  int          cfg_hold = 3;
  int          e_pre = 0;
  int          e_hold = 0;
  logic        e_acc;

  deal_scheduler dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .req_valid(req_valid),
    .req_ready(req_ready), .req_dealer(req_dealer), .req_slot(req_slot),
    .req_card(req_card), .req_err(req_err),
`ifdef HOLE_CARD_EN
    .reveal(reveal),
`endif
    .writeprint(writeprint), .init(init), .card(card), .orig(orig),
    .waitrequest(waitrequest), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] model_orig(input logic dealer, input int slot);
    int x, y;
    x = 4 + slot * 12;
    y = dealer ? 20 : 90;
    return 15'(x * 128 + y);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_wp(input string name, input int lim);
    bit hit = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (writeprint) begin hit = 1; break; end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: writeprint still 0 after %0d cycles, required 1", name, lim);
    end
  endtask

  task automatic wait_idle(input string name, input int lim);
    bit hit = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!busy && !waitrequest) begin hit = 1; break; end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: busy=%0b after %0d cycles, required 0", name, busy, lim);
    end
    step();
  endtask

  task automatic set_req(input logic v, input logic d, input logic [2:0] s, input logic [5:0] c);
    req_valid = v; req_dealer = d; req_slot = s; req_card = c;
  endtask

  // Print-engine model: after acceptance optionally waits, then holds waitrequest high.
  initial begin
    waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      e_acc = writeprint && !waitrequest;
      @(posedge clk); #1;
      if (e_acc) begin
        e_pre  = eng_rand ? int'($urandom_range(0, 2)) : cfg_pre;
        e_hold = eng_rand ? int'($urandom_range(1, 4)) : cfg_hold;
      end
      if (eng_force)                 waitrequest = 1'b1;
      else if (e_pre > 0)            begin waitrequest = 1'b0; e_pre--;  end
      else if (e_hold > 0)           begin waitrequest = 1'b1; e_hold--; end
      else if (eng_rand && writeprint && $urandom_range(0, 3) == 0) waitrequest = 1'b1;
      else                           waitrequest = 1'b0;
    end
  end

  // Monitor: compares each new command against the scoreboard and records accepted requests.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {init, card, orig};
      if (writeprint && !prev_wp) begin
        n_cmds++;
        if (exp_q.size() == 0) begin
          total++; bad++; last_valid = 1'b0;
          $display("FAIL cmd_unexpected: got %h required no command", mon_cur);
        end else begin
          last_exp = exp_q.pop_front();
          last_valid = 1'b1;
          check("cmd", mon_cur, last_exp);
        end
        if (have_acc) check("cmd_gap_seen_hi", {31'd0, wr_hi_since}, 32'd1);
        if (init) clr_wait = 1'b0;
      end else if (writeprint && last_valid) begin
        check("cmd_hold", mon_cur, last_exp);
      end

      check("req_err", {31'd0, req_err}, {31'd0, exp_err});
      exp_err = 1'b0;

      if (writeprint && !waitrequest) begin have_acc = 1'b1; wr_hi_since = 1'b0; end
      else if (waitrequest) wr_hi_since = 1'b1;

      if (clear_req) begin
        exp_q.delete();
        exp_q.push_back(INIT_CMD);
      end else if (req_valid && req_ready) begin
        if (req_card[5:2] == 4'd13 || req_card[5:2] == 4'd15) begin
          exp_err = 1'b1;
        end else begin
          mon_card = req_card;
`ifdef HOLE_CARD_EN
          if (req_dealer && req_slot == 3'd1) begin
            hole_m = req_card;
            mon_card = {4'd14, req_card[1:0]};
          end
`endif
          exp_q.push_back({1'b0, mon_card, model_orig(req_dealer, int'(req_slot))});
        end
      end
`ifdef HOLE_CARD_EN
      if (reveal && !clear_req) exp_q.push_back({1'b0, hole_m, model_orig(1'b1, 1)});
`endif
      prev_wp = writeprint;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n = 1'b0; clear_req = 1'b0;
    set_req(1'b0, 1'b0, 3'd0, 6'd0);
`ifdef HOLE_CARD_EN
    reveal = 1'b0;
`endif
    exp_q.push_back(INIT_CMD);

    repeat (2) @(negedge clk);
    check("rst_writeprint", {31'd0, writeprint}, 32'd0);
    check("rst_init", {31'd0, init}, 32'd0);
    check("rst_card", {26'd0, card}, 32'd0);
    check("rst_orig", {17'd0, orig}, 32'd0);
    check("rst_req_err", {31'd0, req_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    step();
    rst_n = 1'b1; mon_en = 1'b1;

    // Power-up clear with a 3-cycle engine busy period.
    wait_wp("init_issue", 5);
    check("init_flag", {31'd0, init}, 32'd1);
    check("init_orig", {17'd0, orig}, 32'd0);
    check("init_card", {26'd0, card}, 32'd0);
    @(negedge clk);
    check("init_accept_wp", {31'd0, writeprint}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("init_busy_hold", {31'd0, busy}, 32'd1);
    end
    step();
    wait_idle("init_idle", 20);

    // Single player draw.
    set_req(1'b1, 1'b0, 3'd2, 6'b010110);
    step();
    req_valid = 1'b0;
    wait_wp("draw_issue", 10);
    check("draw_orig", {17'd0, orig}, {17'd0, 8'd28, 7'd90});
    check("draw_card", {26'd0, card}, 32'b010110);
    check("draw_init", {31'd0, init}, 32'd0);
    step();
    wait_idle("draw_idle", 20);

    // Fill the FIFO behind a stalled command; the overflow request is ignored.
    n0 = n_cmds;
    eng_force = 1'b1;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 1'(i % 2), 3'(i + 1), {4'(i + 1), 2'(i)});
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("full_ready", {31'd0, req_ready}, 32'd0);
    step();
    set_req(1'b1, 1'b0, 3'd7, 6'b001011);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("full_no_err", {31'd0, req_err}, 32'd0);
    check("full_ready_still", {31'd0, req_ready}, 32'd0);
    step();
    cfg_pre = 1; cfg_hold = 2; eng_force = 1'b0;
    wait_idle("full_drain", 200);
    check("full_cmd_count", n_cmds - n0, 32'd5);
    check("full_queue_empty", exp_q.size(), 32'd0);

    // Rejected rank.
    n0 = n_cmds;
    set_req(1'b1, 1'b0, 3'd0, 6'b110100);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("bad_rank_err", {31'd0, req_err}, 32'd1);
    check("bad_rank_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("bad_rank_err_pulse", {31'd0, req_err}, 32'd0);
    check("bad_rank_no_cmd", {31'd0, writeprint}, 32'd0);
    step();
    set_req(1'b1, 1'b1, 3'd0, 6'b111100);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("rank15_err", {31'd0, req_err}, 32'd1);
    step(); step();
    check("bad_rank_cmds", n_cmds - n0, 32'd0);

    // Clear arriving while a draw is being issued flushes the queued draws.
    n0 = n_cmds;
    cfg_pre = 0; cfg_hold = 2; eng_force = 1'b1;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b1, 3'(i + 3), {4'(i + 2), 2'd3});
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("clr_cmd1_pending", {31'd0, writeprint}, 32'd1);
    step();
    clear_req = 1'b1; clr_wait = 1'b1;
    set_req(1'b1, 1'b0, 3'd6, 6'b000111);
    step();
    clear_req = 1'b0; req_valid = 1'b0;
    eng_force = 1'b0;
    wait_idle("clr_idle", 200);
    check("clr_cmd_count", n_cmds - n0, 32'd2);
    check("clr_queue_empty", exp_q.size(), 32'd0);

`ifdef HOLE_CARD_EN
    set_req(1'b1, 1'b1, 3'd1, 6'b001101);
    step();
    req_valid = 1'b0;
    wait_wp("hole_issue", 10);
    check("hole_card", {26'd0, card}, 32'b111001);
    check("hole_orig", {17'd0, orig}, {17'd0, 8'd16, 7'd20});
    step();
    wait_idle("hole_idle", 20);
    reveal = 1'b1;
    step();
    reveal = 1'b0;
    wait_wp("reveal_issue", 10);
    check("reveal_card", {26'd0, card}, 32'b001101);
    check("reveal_orig", {17'd0, orig}, {17'd0, 8'd16, 7'd20});
    step();
    wait_idle("reveal_idle", 20);
`endif

    // Randomized traffic with a randomized engine.
    eng_rand = 1'b1;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      clear_req = 1'b0;
      req_valid = 1'b0;
      if (!clr_wait && writeprint && $urandom_range(0, 39) == 0) begin
        clear_req = 1'b1;
        clr_wait = 1'b1;
        set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));
      end else if (!clr_wait && $urandom_range(0, 1) == 1) begin
        set_req(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                6'($urandom_range(0, 63)));
      end
      step();
    end
    clear_req = 1'b0;
    req_valid = 1'b0;
    eng_rand = 1'b0;
    wait_idle("rand_drain", 600);
    check("rand_queue_empty", exp_q.size(), 32'd0);
    check("rand_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
